// File: rtl/alarm_zone_ctrl.sv
// Intrusion alarm controller: per-zone input debouncing followed by an
// arm/exit/entry/alarm state machine with a sticky record of triggering zones.
module alarm_zone_ctrl #(
  parameter int                      NUM_ZONES    = 3,
  parameter int                      DEBOUNCE_CYC = 4,
  parameter int                      EXIT_CYC     = 8,
  parameter int                      ENTRY_CYC    = 16,
  parameter logic [NUM_ZONES-1:0]    ENTRY_MASK   = 3'b010
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_ZONES-1:0] zone_in,
  input  logic [NUM_ZONES-1:0] zone_en,
  input  logic                 arm,
  input  logic                 disarm,
  output logic                 alarm,
  output logic                 armed,
  output logic                 pending,
  output logic [NUM_ZONES-1:0] trip_zone
);

  localparam int DLY_MAX = (EXIT_CYC > ENTRY_CYC) ? EXIT_CYC : ENTRY_CYC;
  localparam int CNT_W   = $clog2(DLY_MAX + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [CNT_W-1:0] EXIT_TERM  = CNT_W'(EXIT_CYC - 1);
  localparam logic [CNT_W-1:0] ENTRY_TERM = CNT_W'(ENTRY_CYC - 1);
  localparam logic [DB_W-1:0]  DB_TERM    = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [2:0] {
    S_DISARMED,
    S_EXIT,
    S_ARMED,
    S_ENTRY,
    S_ALARM
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       dly_cnt, dly_cnt_nxt;
  logic [NUM_ZONES-1:0]   trip_nxt;
  logic [NUM_ZONES-1:0]   zdb;
  logic [DB_W-1:0]        db_cnt [NUM_ZONES];
  logic [NUM_ZONES-1:0]   active;
  logic                   hit_instant;
  logic                   hit_entry;

  // Counter advances but holds at its terminal value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] term);
    return (v >= term) ? term : v + CNT_W'(1);
  endfunction

  // Debounce: a zone flips only after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      zdb <= '0;
      for (int i = 0; i < NUM_ZONES; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ZONES; i++) begin
        if (zone_in[i] == zdb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_TERM) begin
          zdb[i]    <= zone_in[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign active      = zdb & zone_en;
  assign hit_instant = |(active & ~ENTRY_MASK);
  assign hit_entry   = |(active & ENTRY_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_DISARMED;
      dly_cnt   <= '0;
      trip_zone <= '0;
    end else begin
      state     <= state_nxt;
      dly_cnt   <= dly_cnt_nxt;
      trip_zone <= trip_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dly_cnt_nxt = dly_cnt;
    trip_nxt    = trip_zone;
    if (disarm) begin
      state_nxt = S_DISARMED;
    end else begin
      case (state)
        S_DISARMED: begin
          if (arm) begin
            state_nxt   = S_EXIT;
            dly_cnt_nxt = '0;
            trip_nxt    = '0;
          end
        end
        S_EXIT: begin
          if (dly_cnt == EXIT_TERM) state_nxt = S_ARMED;
          else                      dly_cnt_nxt = sat_inc(dly_cnt, EXIT_TERM);
        end
        S_ARMED: begin
          trip_nxt = trip_zone | active;
          if (hit_instant) begin
            state_nxt = S_ALARM;
          end else if (hit_entry) begin
            state_nxt   = S_ENTRY;
            dly_cnt_nxt = '0;
          end
        end
        S_ENTRY: begin
          trip_nxt = trip_zone | active;
          if (hit_instant || dly_cnt == ENTRY_TERM) state_nxt = S_ALARM;
          else                                     dly_cnt_nxt = sat_inc(dly_cnt, ENTRY_TERM);
        end
        S_ALARM: state_nxt = S_ALARM;
        default: state_nxt = S_DISARMED;
      endcase
    end
  end

  always_comb begin
    alarm   = (state == S_ALARM);
    armed   = (state == S_ARMED) || (state == S_ENTRY) || (state == S_ALARM);
    pending = (state == S_EXIT) || (state == S_ENTRY);
  end

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Scoreboard bench for alarm_zone_ctrl at default parameters: stimulus queues
// hand-computed expected outputs tagged with a cycle; a monitor compares them.
module tb_alarm_zone_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] zone_in;
  logic [2:0] zone_en;
  logic       arm;
  logic       disarm;
  logic       alarm;
  logic       armed;
  logic       pending;
  logic [2:0] trip_zone;

  alarm_zone_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .zone_in   (zone_in),
    .zone_en   (zone_en),
    .arm       (arm),
    .disarm    (disarm),
    .alarm     (alarm),
    .armed     (armed),
    .pending   (pending),
    .trip_zone (trip_zone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] exp;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected {alarm, armed, pending, trip_zone} for the current cycle.
  task automatic expect_out(input string name, input logic a, input logic ar,
                            input logic p, input logic [2:0] t);
    exp_t e;
    e.cyc  = cyc;
    e.exp  = {a, ar, p, t};
    e.name = name;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    logic [5:0] act;
    exp_t       e;
    act = {alarm, armed, pending, trip_zone};
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never sampled", e.name, e.cyc);
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: cycle %0d got {alarm,armed,pending,trip}=%b_%b_%b_%b want %b_%b_%b_%b",
                 e.name, cyc, act[5], act[4], act[3], act[2:0],
                 e.exp[5], e.exp[4], e.exp[3], e.exp[2:0]);
      end
    end
  end

  // Arm from DISARMED: 8 cycles pending, then ARMED with cleared trip record.
  task automatic arm_seq(input string tag);
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    expect_out({tag, "_exit0"}, 1'b0, 1'b0, 1'b1, 3'b000);
    for (int i = 1; i < 8; i++) begin
      step(1);
      expect_out({tag, "_exit"}, 1'b0, 1'b0, 1'b1, 3'b000);
    end
    step(1);
    expect_out({tag, "_armed"}, 1'b0, 1'b1, 1'b0, 3'b000);
  endtask

  initial begin
    rst = 1'b1; zone_in = '0; zone_en = 3'b111; arm = 1'b0; disarm = 1'b0;
    step(2);
    rst = 1'b0;
    expect_out("reset", 1'b0, 1'b0, 1'b0, 3'b000);
    step(1);

    // Exit delay then instant zone 0: alarm DEBOUNCE_CYC+1 edges after rise.
    arm_seq("inst");
    zone_in = 3'b001;
    step(4);
    expect_out("inst_deb_wait", 1'b0, 1'b1, 1'b0, 3'b000);
    step(1);
    expect_out("inst_alarm", 1'b1, 1'b1, 1'b0, 3'b001);
    zone_in = 3'b000;
    step(6);
    expect_out("alarm_latched", 1'b1, 1'b1, 1'b0, 3'b001);
    disarm = 1'b1;
    step(1);
    disarm = 1'b0;
    expect_out("disarm_keeps_trip", 1'b0, 1'b0, 1'b0, 3'b001);
    step(1);

    // Entry zone, disarmed at cycle 10 of the entry delay.
    arm_seq("ent1");
    zone_in = 3'b010;
    step(4);
    expect_out("ent1_deb_wait", 1'b0, 1'b1, 1'b0, 3'b000);
    step(1);
    expect_out("ent1_entry", 1'b0, 1'b1, 1'b1, 3'b010);
    step(9);
    expect_out("ent1_entry_c10", 1'b0, 1'b1, 1'b1, 3'b010);
    disarm = 1'b1;
    step(1);
    disarm = 1'b0;
    expect_out("ent1_disarm", 1'b0, 1'b0, 1'b0, 3'b010);
    zone_in = 3'b000;
    step(5);

    // Entry delay expiry.
    arm_seq("ent2");
    zone_in = 3'b010;
    step(5);
    expect_out("ent2_entry", 1'b0, 1'b1, 1'b1, 3'b010);
    step(15);
    expect_out("ent2_last_entry", 1'b0, 1'b1, 1'b1, 3'b010);
    step(1);
    expect_out("ent2_alarm", 1'b1, 1'b1, 1'b0, 3'b010);
    disarm = 1'b1;
    step(1);
    disarm = 1'b0;
    zone_in = 3'b000;
    step(5);

    // Glitch rejection and disabled zone.
    arm_seq("glt");
    zone_in = 3'b100;
    step(3);
    zone_in = 3'b000;
    step(6);
    expect_out("glitch_ignored", 1'b0, 1'b1, 1'b0, 3'b000);
    zone_en = 3'b011;
    zone_in = 3'b100;
    step(8);
    expect_out("disabled_zone", 1'b0, 1'b1, 1'b0, 3'b000);
    zone_in = 3'b000;
    step(5);
    zone_en = 3'b111;
    step(1);

    // Entry from zone 1, then instant zone 0 joins during the entry delay.
    zone_in = 3'b010;
    step(5);
    expect_out("mix_entry", 1'b0, 1'b1, 1'b1, 3'b010);
    zone_in = 3'b011;
    step(4);
    expect_out("mix_deb_wait", 1'b0, 1'b1, 1'b1, 3'b010);
    step(1);
    expect_out("mix_alarm", 1'b1, 1'b1, 1'b0, 3'b011);
    zone_in = 3'b000;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_out("rst_in_alarm", 1'b0, 1'b0, 1'b0, 3'b000);
    step(1);

    // arm and disarm together: disarm wins.
    arm = 1'b1; disarm = 1'b1;
    step(1);
    arm = 1'b0; disarm = 1'b0;
    expect_out("arm_disarm_same", 1'b0, 1'b0, 1'b0, 3'b000);
    step(1);
    expect_out("arm_disarm_stay", 1'b0, 1'b0, 1'b0, 3'b000);

    // A second arm during EXIT must not reload the exit counter.
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    step(3);
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    step(3);
    expect_out("rearm_exit7", 1'b0, 1'b0, 1'b1, 3'b000);
    step(1);
    expect_out("rearm_armed", 1'b0, 1'b1, 1'b0, 3'b000);
    disarm = 1'b1;
    step(1);
    disarm = 1'b0;

    // Reset in the middle of the exit delay.
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_out("rst_in_exit", 1'b0, 1'b0, 1'b0, 3'b000);
    step(9);
    expect_out("rst_exit_stays", 1'b0, 1'b0, 1'b0, 3'b000);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      errors += sbq.size();
      checks += sbq.size();
      $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_zone_ctrl.md
ALARM_ZONE_CTRL -- requirements
Module: alarm_zone_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ZONES, default 3, number of sensor zones (1..8).
REQ-002 The block SHALL have parameter DEBOUNCE_CYC, default 4, consecutive stable cycles required to accept a zone change (>=1).
REQ-003 The block SHALL have parameter EXIT_CYC, default 8, exit-delay length in cycles (>=1).
REQ-004 The block SHALL have parameter ENTRY_CYC, default 16, entry-delay length in cycles (>=1).
REQ-005 The block SHALL have parameter ENTRY_MASK, default 3'b010, NUM_ZONES bits, 1 = delayed (entry) zone, 0 = instant zone.
REQ-006 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 The block SHALL have port zone_in  input  NUM_ZONES  raw sensor levels, 1 = tripped; bit 0 motion, bit 1 door, bit 2 window at default.
REQ-009 The block SHALL have port zone_en  input  NUM_ZONES  per-zone enable; disabled zones never trigger.
REQ-010 The block SHALL have port arm  input  1  single-cycle arm request.
REQ-011 The block SHALL have port disarm  input  1  single-cycle disarm request.
REQ-012 The block SHALL have port alarm  output  1  high only in state ALARM.
REQ-013 The block SHALL have port armed  output  1  high in ARMED, ENTRY or ALARM.
REQ-014 The block SHALL have port pending  output  1  high in EXIT or ENTRY.
REQ-015 The block SHALL have port trip_zone  output  NUM_ZONES  sticky record of zones that caused a trigger.

Function
REQ-016 Each zone SHALL have an independent debouncer: debounced bit zdb[i] takes the raw value after raw differs from zdb[i] on DEBOUNCE_CYC consecutive rising edges; any edge with raw == zdb[i] clears that zone's counter.
REQ-017 A zone SHALL be active when zdb[i] & zone_en[i]; zone_en is applied after debouncing, unregistered.
REQ-018 The FSM SHALL have states DISARMED, EXIT, ARMED, ENTRY, ALARM, one transition per edge.
REQ-019 DISARMED: arm=1 -> EXIT, load exit counter, clear trip_zone; zones ignored.
REQ-020 EXIT: zones ignored; counter reaches EXIT_CYC edges after entry -> ARMED.
REQ-021 ARMED: any active instant zone -> ALARM; else any active entry zone -> ENTRY, load entry counter; trip_zone |= active zones on that edge.
REQ-022 ENTRY: active instant zone -> ALARM; counter reaches ENTRY_CYC edges after entry -> ALARM; trip_zone keeps ORing active zones.
REQ-023 ALARM: SHALL latch; zones clearing SHALL NOT leave ALARM; only disarm or rst exit.
REQ-024 disarm=1 in any state SHALL go to DISARMED on the next edge; trip_zone SHALL be retained.
REQ-025 arm and disarm in the same cycle: disarm SHALL win.
REQ-026 arm outside DISARMED SHALL be ignored (no counter reload).
REQ-027 Outputs SHALL be registered-state decodes, valid the cycle after the transition edge.
REQ-028 Counters SHALL be sized ceil(log2(max+1)) and SHALL NOT wrap; they stop at terminal count.
REQ-029 Instant-zone latency: raw rise while ARMED -> alarm high after DEBOUNCE_CYC+1 edges.

Reset
REQ-030 rst=1 on an edge SHALL force DISARMED, all counters 0, zdb=0, trip_zone=0, alarm=0, armed=0, pending=0, overriding arm/disarm.
REQ-031 rst asserted mid-EXIT, mid-ENTRY or in ALARM SHALL give the same result as REQ-030 on the next edge.

Verification (defaults)
REQ-032 arm pulse, zone_in=000 -> pending=1 for 8 cycles, then armed=1, pending=0, alarm=0.
REQ-033 ARMED, zone_en=111, zone_in=001 held -> alarm=1 after 5 edges, trip_zone=001; zone_in back to 000 -> alarm stays 1; disarm -> alarm=0, armed=0, trip_zone=001.
REQ-034 ARMED, zone_in=010 held -> ENTRY (pending=1) after 5 edges; disarm at cycle 10 of ENTRY -> DISARMED, alarm never 1; repeat without disarm -> alarm=1 after 16 ENTRY cycles.
REQ-035 ARMED, zone_in=100 glitch 3 cycles then 000 -> no state change; zone_en=011 with zone_in=100 held -> no alarm.
REQ-036 ENTRY from zone 1, then zone_in=011 held -> ALARM 5 edges after zone 0 rises, trip_zone=011.
REQ-037 arm and disarm same cycle in DISARMED -> stays DISARMED; rst during ALARM -> all outputs 0 next cycle.
